// File: rtl/pllcfg_pkg.sv
// Shared definitions for the PLL reconfiguration management responder:
// register addresses, field positions, FSM states and the phase saturation helper.
package pllcfg_pkg;

    localparam int CNT_W = 18;
    localparam int TMR_W = 16;

    localparam logic [5:0] PLLCFG_MODE   = 6'd0;
    localparam logic [5:0] PLLCFG_STATUS = 6'd1;
    localparam logic [5:0] PLLCFG_APPLY  = 6'd2;
    localparam logic [5:0] PLLCFG_N      = 6'd3;
    localparam logic [5:0] PLLCFG_M      = 6'd4;
    localparam logic [5:0] PLLCFG_C      = 6'd5;
    localparam logic [5:0] PLLCFG_PHASE  = 6'd6;
    localparam logic [5:0] PLLCFG_K      = 6'd7;
    localparam logic [5:0] PLLCFG_BW     = 6'd8;
    localparam logic [5:0] PLLCFG_CP     = 6'd9;

    localparam int C_SEL_LSB    = 18;
    localparam int C_SEL_MSB    = 22;
    localparam int PH_STEPS_MSB = 15;
    localparam int PH_SEL_LSB   = 16;
    localparam int PH_SEL_MSB   = 20;
    localparam int PH_DIR_BIT   = 21;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_RELOCK = 2'd2,
        ST_PHASE  = 2'd3
    } state_t;

    // One phase step; saturates at max_val going up and at 0 going down.
    function automatic logic [15:0] phase_adj(input logic [15:0] cur, input logic dec,
                                              input logic [15:0] max_val);
        logic [15:0] r;
        if (dec) r = (cur == 16'd0) ? 16'd0 : cur - 16'd1;
        else     r = (cur >= max_val) ? max_val : cur + 16'd1;
        return r;
    endfunction

endpackage

// File: rtl/pllcfg_lock_timer.sv
// Loadable down-counter with hold and zero flag, shared by the relock wait
// and the per-step phase pacing.
module pllcfg_lock_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         hold,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Reset is expressed by the owner driving load, so no reset port is needed.
    always_ff @(posedge clk) begin
        if (load)
            cnt_q <= load_val;
        else if (!hold && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pll_mgmt_responder.sv
// Avalon-MM responder modelling the PLL reconfig IP: shadow/active register sets,
// lock loss and re-acquisition, and paced phase stepping. Macro PLLCFG_READBACK_EN adds shadow readback.
module pll_mgmt_responder
    import pllcfg_pkg::*;
#(
    parameter int          LOCK_CYCLES       = 64,
    parameter int          PHASE_STEP_CYCLES = 4,
    parameter logic [15:0] PHASE_MAX         = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  mgmt_address,
    input  logic        mgmt_write,
    input  logic [31:0] mgmt_writedata,
    input  logic        mgmt_read,
    output logic [31:0] mgmt_readdata,
    output logic        mgmt_waitrequest,
    input  logic        pll_reset,
    output logic        locked,
    output logic        busy,
    output logic [17:0] cfg_m,
    output logic [17:0] cfg_n,
    output logic [17:0] cfg_c0,
    output logic [17:0] cfg_c1,
    output logic [31:0] cfg_k,
    output logic [15:0] phase_c0,
    output logic [15:0] phase_c1,
    output logic [1:0]  dbg_state
);

    localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] STEP_LOAD = TMR_W'(PHASE_STEP_CYCLES - 1);

    // Handshake: a write is taken on a rising edge only when the FSM is IDLE and
    // waitrequest is low; a read is always taken and mgmt_readdata is valid the next clock.

    state_t state_q, state_d;
    logic   wait_q, locked_q, relock_pending;

    logic             mode_q;
    logic [CNT_W-1:0] sh_n, sh_m, sh_c0, sh_c1;
    logic [31:0]      sh_k;
    logic [21:0]      sh_ph;
`ifdef PLLCFG_READBACK_EN
    logic [31:0]      sh_c_word;
    logic [3:0]       sh_bw;
    logic [2:0]       sh_cp;
`endif

    logic [15:0] ph_steps;
    logic [4:0]  ph_sel;
    logic        ph_dec;

    logic        wr_acc, apply_go, relock_done, phase_run, phase_skip, step_now;
    logic        tmr_load, tmr_hold, tmr_zero;
    logic [TMR_W-1:0] tmr_val;
    logic [31:0] rd_val;

    assign wr_acc      = mgmt_write && (state_q == ST_IDLE) && !wait_q;
    assign apply_go    = (state_q == ST_APPLY) && !pll_reset;
    assign relock_done = relock_pending && !pll_reset && tmr_zero;
    assign phase_run   = (state_q == ST_PHASE) && !pll_reset && !relock_pending;
    assign phase_skip  = (ph_steps == 16'd0) || (ph_sel > 5'd1);
    assign step_now    = phase_run && !phase_skip && tmr_zero;

    always_comb begin
        state_d = state_q;
        if (!pll_reset) begin
            case (state_q)
                ST_IDLE:   if (wr_acc && mgmt_address == PLLCFG_APPLY) state_d = ST_APPLY;
                ST_APPLY:  state_d = ST_RELOCK;
                ST_RELOCK: if (relock_done) state_d = ST_PHASE;
                ST_PHASE:  if (phase_run && (phase_skip || (tmr_zero && ph_steps == 16'd1)))
                               state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // One timer: relock countdown first, then reloaded as the phase step pacer.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = LOCK_LOAD;
        if (reset || pll_reset || apply_go) begin
            tmr_load = 1'b1;
        end else if (relock_done && (state_q == ST_RELOCK || state_q == ST_PHASE)) begin
            tmr_load = 1'b1;
            tmr_val  = STEP_LOAD;
        end else if (step_now) begin
            tmr_load = 1'b1;
            tmr_val  = STEP_LOAD;
        end
        tmr_hold = (state_q == ST_IDLE) && !relock_pending;
    end

    pllcfg_lock_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .hold     (tmr_hold),
        .zero     (tmr_zero)
    );

    always_comb begin
        rd_val = 32'd0;
        case (mgmt_address)
            PLLCFG_STATUS: rd_val = {31'd0, state_q == ST_IDLE};
`ifdef PLLCFG_READBACK_EN
            PLLCFG_MODE:   rd_val = {31'd0, mode_q};
            PLLCFG_N:      rd_val = {14'd0, sh_n};
            PLLCFG_M:      rd_val = {14'd0, sh_m};
            PLLCFG_C:      rd_val = sh_c_word;
            PLLCFG_PHASE:  rd_val = {10'd0, sh_ph};
            PLLCFG_K:      rd_val = sh_k;
            PLLCFG_BW:     rd_val = {28'd0, sh_bw};
            PLLCFG_CP:     rd_val = {29'd0, sh_cp};
`endif
            default:       rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            wait_q         <= 1'b0;
            locked_q       <= 1'b0;
            relock_pending <= 1'b1;
            mgmt_readdata  <= 32'd0;
            mode_q         <= 1'b0;
            sh_n           <= '0;
            sh_m           <= '0;
            sh_c0          <= '0;
            sh_c1          <= '0;
            sh_k           <= 32'd0;
            sh_ph          <= 22'd0;
`ifdef PLLCFG_READBACK_EN
            sh_c_word      <= 32'd0;
            sh_bw          <= 4'd0;
            sh_cp          <= 3'd0;
`endif
            cfg_m          <= '0;
            cfg_n          <= '0;
            cfg_c0         <= '0;
            cfg_c1         <= '0;
            cfg_k          <= 32'd1;
            phase_c0       <= 16'd0;
            phase_c1       <= 16'd0;
            ph_steps       <= 16'd0;
            ph_sel         <= 5'd0;
            ph_dec         <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= !mode_q && (state_d != ST_IDLE);

            if (mgmt_read)
                mgmt_readdata <= rd_val;

            if (wr_acc) begin
                case (mgmt_address)
                    PLLCFG_MODE:  mode_q <= mgmt_writedata[0];
                    PLLCFG_N:     sh_n   <= mgmt_writedata[CNT_W-1:0];
                    PLLCFG_M:     sh_m   <= mgmt_writedata[CNT_W-1:0];
                    PLLCFG_C: begin
`ifdef PLLCFG_READBACK_EN
                        sh_c_word <= mgmt_writedata;
`endif
                        if (mgmt_writedata[C_SEL_MSB:C_SEL_LSB] == 5'd0)
                            sh_c0 <= mgmt_writedata[CNT_W-1:0];
                        else if (mgmt_writedata[C_SEL_MSB:C_SEL_LSB] == 5'd1)
                            sh_c1 <= mgmt_writedata[CNT_W-1:0];
                    end
                    PLLCFG_PHASE: sh_ph  <= mgmt_writedata[PH_DIR_BIT:0];
                    PLLCFG_K:     sh_k   <= mgmt_writedata;
`ifdef PLLCFG_READBACK_EN
                    PLLCFG_BW:    sh_bw  <= mgmt_writedata[3:0];
                    PLLCFG_CP:    sh_cp  <= mgmt_writedata[2:0];
`endif
                    default: ;
                endcase
            end

            if (pll_reset || apply_go) begin
                locked_q       <= 1'b0;
                relock_pending <= 1'b1;
            end else if (relock_done) begin
                locked_q       <= 1'b1;
                relock_pending <= 1'b0;
            end

            if (apply_go) begin
                cfg_m    <= sh_m;
                cfg_n    <= sh_n;
                cfg_c0   <= sh_c0;
                cfg_c1   <= sh_c1;
                cfg_k    <= sh_k;
                ph_steps <= sh_ph[PH_STEPS_MSB:0];
                ph_sel   <= sh_ph[PH_SEL_MSB:PH_SEL_LSB];
                ph_dec   <= sh_ph[PH_DIR_BIT];
                sh_ph[PH_STEPS_MSB:0] <= 16'd0;
            end

            // Saturated steps still consume the request count.
            if (step_now) begin
                ph_steps <= ph_steps - 16'd1;
                if (ph_sel[0]) phase_c1 <= phase_adj(phase_c1, ph_dec, PHASE_MAX);
                else           phase_c0 <= phase_adj(phase_c0, ph_dec, PHASE_MAX);
            end
        end
    end

    assign mgmt_waitrequest = wait_q;
    assign locked           = locked_q;
    assign busy             = (state_q != ST_IDLE);
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_pll_mgmt_responder.sv
// Directed bench for pll_mgmt_responder: register writes, Apply/relock timing,
// phase stepping, polling mode, pll_reset freeze and mid-sequence reset.
module tb_pll_mgmt_responder;

    logic        clk;
    logic        reset;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_read;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic        pll_reset;
    logic        locked;
    logic        busy;
    logic [17:0] cfg_m, cfg_n, cfg_c0, cfg_c1;
    logic [31:0] cfg_k;
    logic [15:0] phase_c0, phase_c1;
    logic [1:0]  dbg_state;

    int n_vec;
    int n_err;

    pll_mgmt_responder dut (
        .clk              (clk),
        .reset            (reset),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_read        (mgmt_read),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_reset        (pll_reset),
        .locked           (locked),
        .busy             (busy),
        .cfg_m            (cfg_m),
        .cfg_n            (cfg_n),
        .cfg_c0           (cfg_c0),
        .cfg_c1           (cfg_c1),
        .cfg_k            (cfg_k),
        .phase_c0         (phase_c0),
        .phase_c1         (phase_c1),
        .dbg_state        (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the write until waitrequest is seen low before an edge; returns #1 after that edge.
    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        int   budget;
        logic w;
        mgmt_address   = a;
        mgmt_writedata = d;
        mgmt_write     = 1'b1;
        budget         = 300;
        do begin
            w = mgmt_waitrequest;
            @(posedge clk);
            #1;
            budget--;
        end while (w && budget > 0);
        mgmt_write = 1'b0;
        n_vec++;
        if (w) begin
            n_err++;
            $display("FAIL wr_timeout addr=%0d: waitrequest still %b, required 0", a, w);
        end
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        mgmt_address = a;
        mgmt_read    = 1'b1;
        @(posedge clk);
        #1;
        mgmt_read = 1'b0;
        d = mgmt_readdata;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL rst_locked got %b want 0", locked); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_vec++; if (mgmt_waitrequest !== 1'b0) begin n_err++; $display("FAIL rst_wait got %b want 0", mgmt_waitrequest); end
        n_vec++; if (mgmt_readdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata got %h want 0", mgmt_readdata); end
        n_vec++; if (cfg_k !== 32'd1) begin n_err++; $display("FAIL rst_cfg_k got %h want 1", cfg_k); end
        n_vec++; if ({cfg_m, cfg_n, cfg_c0, cfg_c1} !== 72'd0) begin n_err++; $display("FAIL rst_cfg got %h want 0", {cfg_m, cfg_n, cfg_c0, cfg_c1}); end
        n_vec++; if ({phase_c0, phase_c1} !== 32'd0) begin n_err++; $display("FAIL rst_phase got %h want 0", {phase_c0, phase_c1}); end
        tick(63);
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL rst_lock_63 got %b want 0", locked); end
        tick(1);
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL rst_lock_64 got %b want 1", locked); end
        tick(6);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_apply;
        logic [31:0] d;
        wr(6'd4, 32'h0000_0808);
        wr(6'd7, 32'hB333_32DD);
        wr(6'd5, 32'h0002_0302);
        wr(6'd5, 32'h0006_0302);
        wr(6'd2, 32'd0);
        n_vec++; if (mgmt_waitrequest !== 1'b1) begin n_err++; $display("FAIL apply_wait got %b want 1", mgmt_waitrequest); end
        n_vec++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL apply_state got %0d want 1", dbg_state); end
        tick(1);
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL apply_unlock got %b want 0", locked); end
        n_vec++; if (cfg_m !== 18'h00808) begin n_err++; $display("FAIL apply_cfg_m got %h want 00808", cfg_m); end
        n_vec++; if (cfg_c0 !== 18'h20302) begin n_err++; $display("FAIL apply_cfg_c0 got %h want 20302", cfg_c0); end
        n_vec++; if (cfg_c1 !== 18'h20302) begin n_err++; $display("FAIL apply_cfg_c1 got %h want 20302", cfg_c1); end
        n_vec++; if (cfg_k !== 32'hB333_32DD) begin n_err++; $display("FAIL apply_cfg_k got %h want b33332dd", cfg_k); end
        n_vec++; if (cfg_n !== 18'd0) begin n_err++; $display("FAIL apply_cfg_n got %h want 0", cfg_n); end
        tick(4);
        rd(6'd1, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL apply_status_busy got %h want 0", d); end
        tick(58);
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL apply_lock_64 got %b want 0", locked); end
        tick(1);
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL apply_lock_65 got %b want 1", locked); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL apply_busy_phase got %b want 1", busy); end
        tick(1);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL apply_idle got %b want 0", busy); end
        n_vec++; if (mgmt_waitrequest !== 1'b0) begin n_err++; $display("FAIL apply_wait_idle got %b want 0", mgmt_waitrequest); end
        rd(6'd4, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rd_unreadable got %h want 0", d); end
    endtask

    task automatic test_phase_inc;
        wr(6'd6, 32'h0001_001D);
        wr(6'd2, 32'd0);
        tick(180);
        n_vec++; if (phase_c1 !== 16'd28) begin n_err++; $display("FAIL inc_c1_mid got %0d want 28", phase_c1); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL inc_busy_mid got %b want 1", busy); end
        tick(1);
        n_vec++; if (phase_c1 !== 16'd29) begin n_err++; $display("FAIL inc_c1_end got %0d want 29", phase_c1); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL inc_idle got %b want 0", busy); end
        wr(6'd6, 32'h0021_0005);
        wr(6'd2, 32'd0);
        tick(84);
        n_vec++; if (phase_c1 !== 16'd25) begin n_err++; $display("FAIL dec_c1_mid got %0d want 25", phase_c1); end
        tick(1);
        n_vec++; if (phase_c1 !== 16'd24) begin n_err++; $display("FAIL dec_c1_end got %0d want 24", phase_c1); end
        n_vec++; if (phase_c0 !== 16'd0) begin n_err++; $display("FAIL dec_c0_untouched got %0d want 0", phase_c0); end
    endtask

    task automatic test_phase_saturate;
        wr(6'd6, 32'h0000_0002);
        wr(6'd2, 32'd0);
        tick(73);
        n_vec++; if (phase_c0 !== 16'd2) begin n_err++; $display("FAIL sat_c0_pre got %0d want 2", phase_c0); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sat_pre_idle got %b want 0", busy); end
        wr(6'd6, 32'h0020_0005);
        wr(6'd2, 32'd0);
        tick(84);
        n_vec++; if (phase_c0 !== 16'd0) begin n_err++; $display("FAIL sat_c0_floor got %0d want 0", phase_c0); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL sat_steps_left got %b want 1", busy); end
        tick(1);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL sat_idle got %b want 0", busy); end
        // Shadow steps were cleared by Apply, so a bare Apply skips PHASE.
        wr(6'd2, 32'd0);
        tick(66);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL steps_cleared_idle got %b want 0", busy); end
        n_vec++; if ({phase_c0, phase_c1} !== {16'd0, 16'd24}) begin n_err++; $display("FAIL steps_cleared_phase got %h want 00000018", {phase_c0, phase_c1}); end
    endtask

    task automatic test_polling;
        logic [31:0] d;
        wr(6'd0, 32'd1);
        wr(6'd2, 32'd0);
        n_vec++; if (mgmt_waitrequest !== 1'b0) begin n_err++; $display("FAIL poll_wait got %b want 0", mgmt_waitrequest); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL poll_busy got %b want 1", busy); end
        tick(5);
        rd(6'd1, d);
        n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL poll_status_busy got %h want 0", d); end
        wr(6'd4, 32'h0000_0123);
        n_vec++; if (mgmt_waitrequest !== 1'b0) begin n_err++; $display("FAIL poll_wait_relock got %b want 0", mgmt_waitrequest); end
        tick(59);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL poll_idle got %b want 0", busy); end
        rd(6'd1, d);
        n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL poll_status_done got %h want 1", d); end
        wr(6'd2, 32'd0);
        tick(66);
        n_vec++; if (cfg_m !== 18'h00808) begin n_err++; $display("FAIL poll_dropped_m got %h want 00808", cfg_m); end
        wr(6'd0, 32'd0);
    endtask

    task automatic test_pll_reset;
        int bad;
        wr(6'd2, 32'd0);
        tick(10);
        pll_reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (locked !== 1'b0 || busy !== 1'b1) bad++;
        end
        pll_reset = 1'b0;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL pllrst_hold bad_cycles=%0d want 0", bad); end
        tick(63);
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL pllrst_lock_63 got %b want 0", locked); end
        tick(1);
        n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL pllrst_lock_64 got %b want 1", locked); end
        tick(1);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL pllrst_idle got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_phase;
        wr(6'd6, 32'h0000_0010);
        wr(6'd2, 32'd0);
        tick(70);
        n_vec++; if (phase_c0 !== 16'd1) begin n_err++; $display("FAIL midrst_pre_c0 got %0d want 1", phase_c0); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_vec++; if (busy !== 1'b0 || mgmt_waitrequest !== 1'b0 || locked !== 1'b0) begin n_err++; $display("FAIL midrst_ctl got busy=%b wait=%b lock=%b want 0 0 0", busy, mgmt_waitrequest, locked); end
        n_vec++; if (cfg_k !== 32'd1 || {cfg_m, cfg_n, cfg_c0, cfg_c1} !== 72'd0) begin n_err++; $display("FAIL midrst_cfg got k=%h m=%h want k=1 rest 0", cfg_k, cfg_m); end
        n_vec++; if ({phase_c0, phase_c1} !== 32'd0 || mgmt_readdata !== 32'd0) begin n_err++; $display("FAIL midrst_phase got %h rd=%h want 0", {phase_c0, phase_c1}, mgmt_readdata); end
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        reset          = 1'b1;
        mgmt_address   = 6'd0;
        mgmt_write     = 1'b0;
        mgmt_writedata = 32'd0;
        mgmt_read      = 1'b0;
        pll_reset      = 1'b0;
        test_reset;
        test_apply;
        test_phase_inc;
        test_phase_saturate;
        test_polling;
        test_pll_reset;
        test_reset_mid_phase;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
